i2c_mem_slave: RTL and testbench

I2C target that sits on the sda/scl bus driven by the team's I2C master and acts as its downstream consumer: a 128x8 byte memory. The first byte after START is {mem_addr[6:0], rw}; rw=0 writes subsequent data bytes into memory, rw=1 returns memory bytes to the master. The address auto-increments per byte and wraps 127->0. The block is clocked by the system clock and oversamples the bus; there is no clock stretching.

---
 rtl/i2c_pkg.sv | 26 ++
 rtl/i2c_bus_sync.sv | 51 +++++
 rtl/i2c_mem_slave.sv | 180 ++++++++++++++++++
 tb/tb_i2c_mem_slave.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
`default_nettype none
// ---------------------------------------------------------------
// i2c_pkg : shared I2C types and constants (slave states, widths, ACK levels)
// Rev 1.0
// ---------------------------------------------------------------
package i2c_pkg;

  localparam int I2C_ADDR_W = 7;
  localparam int I2C_BYTE_W = 8;

  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ADDR      = 3'd1,
    ADDR_ACK  = 3'd2,
    WR_BYTE   = 3'd3,
    WR_ACK    = 3'd4,
    RD_BYTE   = 3'd5,
    MST_ACK   = 3'd6,
    WAIT_STOP = 3'd7
  } slv_state_t;

endpackage
`default_nettype wire

// File: rtl/i2c_bus_sync.sv
`default_nettype none
// ---------------------------------------------------------------
// i2c_bus_sync : scl/sda synchroniser with edge, START and STOP strobes
// Rev 1.0
// ---------------------------------------------------------------
module i2c_bus_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic scl,
  input  logic sda,
  output logic sda_s,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  localparam int STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  logic [STAGES-1:0] r_scl_sync;
  logic [STAGES-1:0] r_sda_sync;
  logic              r_scl_prev;
  logic              r_sda_prev;
  logic              w_scl_s;

  // Reset to the idle bus level so no spurious edge appears after reset
  always_ff @(posedge clk) begin
    if (rst) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
      r_scl_prev <= 1'b1;
      r_sda_prev <= 1'b1;
    end else begin
      r_scl_sync <= {r_scl_sync[STAGES-2:0], scl};
      r_sda_sync <= {r_sda_sync[STAGES-2:0], sda};
      r_scl_prev <= r_scl_sync[STAGES-1];
      r_sda_prev <= r_sda_sync[STAGES-1];
    end
  end

  assign w_scl_s   = r_scl_sync[STAGES-1];
  assign sda_s     = r_sda_sync[STAGES-1];
  assign scl_rise  = w_scl_s & ~r_scl_prev;
  assign scl_fall  = ~w_scl_s & r_scl_prev;
  assign start_det = w_scl_s & r_scl_prev & r_sda_prev & ~sda_s;
  assign stop_det  = w_scl_s & r_scl_prev & ~r_sda_prev & sda_s;

endmodule
`default_nettype wire

// File: rtl/i2c_mem_slave.sv
`default_nettype none
// ---------------------------------------------------------------
// i2c_mem_slave : oversampling I2C target backed by a 128x8 register memory
// Rev 1.0
// ---------------------------------------------------------------
module i2c_mem_slave import i2c_pkg::*; #(
  parameter int freqSystem  = 50000000,
  parameter int SYNC_STAGES = 2,
  parameter int DEPTH       = 128
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl,
  inout  wire        sda,
  output logic       busy,
  output logic       wr_done,
  output logic       rd_done,
  output logic       ack_err,
  input  logic [6:0] dbg_addr,
  output logic [7:0] dbg_data
);

  if (DEPTH != 128 || freqSystem <= 0) begin : g_param_check
    $error("i2c_mem_slave: DEPTH must be 128 and freqSystem positive");
  end

  logic [I2C_BYTE_W-1:0] r_mem [DEPTH];
  slv_state_t            r_state;
  logic [3:0]            r_cnt;
  logic [I2C_BYTE_W-1:0] r_shift;
  logic [I2C_ADDR_W-1:0] r_ptr;
  logic                  r_rw;
  logic                  r_phase;
  logic                  r_sda_out;
  logic                  r_busy;
  logic                  r_wr_done;
  logic                  r_rd_done;

  logic                  w_sda_s;
  logic                  w_scl_rise;
  logic                  w_scl_fall;
  logic                  w_start;
  logic                  w_stop;
  logic [I2C_BYTE_W-1:0] w_rx_byte;
  logic [I2C_ADDR_W-1:0] w_ptr_next;

  i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk       (clk),
    .rst       (rst),
    .scl       (scl),
    .sda       (sda),
    .sda_s     (w_sda_s),
    .scl_rise  (w_scl_rise),
    .scl_fall  (w_scl_fall),
    .start_det (w_start),
    .stop_det  (w_stop)
  );

  assign w_rx_byte  = {r_shift[I2C_BYTE_W-2:0], w_sda_s};
  assign w_ptr_next = r_ptr + 7'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= 4'd0;
      r_shift   <= '0;
      r_ptr     <= '0;
      r_rw      <= 1'b0;
      r_phase   <= 1'b0;
      r_sda_out <= NACK;
      r_busy    <= 1'b0;
      r_wr_done <= 1'b0;
      r_rd_done <= 1'b0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      r_wr_done <= 1'b0;
      r_rd_done <= 1'b0;
      if (w_start) begin
        r_state   <= ADDR;
        r_cnt     <= 4'd0;
        r_busy    <= 1'b1;
        r_sda_out <= NACK;
        r_phase   <= 1'b0;
      end else if (w_stop) begin
        r_state   <= IDLE;
        r_sda_out <= NACK;
        r_busy    <= 1'b0;
      end else begin
        case (r_state)
          ADDR: if (w_scl_rise) begin
            r_shift <= w_rx_byte;
            if (r_cnt == 4'd7) begin
              r_ptr   <= w_rx_byte[7:1];
              r_rw    <= w_rx_byte[0];
              r_cnt   <= 4'd0;
              r_phase <= 1'b0;
              r_state <= ADDR_ACK;
            end else begin
              r_cnt <= r_cnt + 4'd1;
            end
          end
          // First fall starts the ACK slot, second fall ends it
          ADDR_ACK: if (w_scl_fall) begin
            if (!r_phase) begin
              r_sda_out <= ACK;
              r_phase   <= 1'b1;
            end else if (r_rw) begin
              r_shift   <= r_mem[r_ptr];
              r_sda_out <= r_mem[r_ptr][7];
              r_cnt     <= 4'd1;
              r_state   <= RD_BYTE;
            end else begin
              r_sda_out <= NACK;
              r_cnt     <= 4'd0;
              r_state   <= WR_BYTE;
            end
          end
          WR_BYTE: if (w_scl_rise) begin
            r_shift <= w_rx_byte;
            if (r_cnt == 4'd7) begin
              r_mem[r_ptr] <= w_rx_byte;
              r_wr_done    <= 1'b1;
              r_ptr        <= w_ptr_next;
              r_cnt        <= 4'd0;
              r_phase      <= 1'b0;
              r_state      <= WR_ACK;
            end else begin
              r_cnt <= r_cnt + 4'd1;
            end
          end
          WR_ACK: if (w_scl_fall) begin
            if (!r_phase) begin
              r_sda_out <= ACK;
              r_phase   <= 1'b1;
            end else begin
              r_sda_out <= NACK;
              r_cnt     <= 4'd0;
              r_state   <= WR_BYTE;
            end
          end
          // r_cnt counts bits already on the bus; bit 6 of r_shift is always the next one
          RD_BYTE: if (w_scl_fall) begin
            if (r_cnt == 4'd8) begin
              r_sda_out <= NACK;
              r_state   <= MST_ACK;
            end else if (r_cnt == 4'd0) begin
              r_sda_out <= r_shift[7];
              r_cnt     <= 4'd1;
            end else begin
              r_sda_out <= r_shift[6];
              r_shift   <= {r_shift[6:0], 1'b0};
              r_cnt     <= r_cnt + 4'd1;
            end
          end
          MST_ACK: if (w_scl_rise) begin
            r_rd_done <= 1'b1;
            if (w_sda_s == ACK) begin
              r_ptr   <= w_ptr_next;
              r_shift <= r_mem[w_ptr_next];
              r_cnt   <= 4'd0;
              r_state <= RD_BYTE;
            end else begin
              r_state <= WAIT_STOP;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign sda      = r_sda_out ? 1'bz : 1'b0;
  assign busy     = r_busy;
  assign wr_done  = r_wr_done;
  assign rd_done  = r_rd_done;
  assign ack_err  = 1'b0;
  assign dbg_data = r_mem[dbg_addr];

endmodule
`default_nettype wire

// File: tb/tb_i2c_mem_slave.sv
`default_nettype none
// ---------------------------------------------------------------
// tb_i2c_mem_slave : bit-banged I2C master, memory model and read-data scoreboard
// Rev 1.0
// ---------------------------------------------------------------
module tb_i2c_mem_slave;

  localparam int Q = 6;

  logic       clk = 1'b0;
  logic       rst;
  logic       scl;
  logic       sda_low;
  wire        sda;
  logic       busy, wr_done, rd_done, ack_err;
  logic [6:0] dbg_addr;
  logic [7:0] dbg_data;

  pullup (sda);
  assign sda = sda_low ? 1'b0 : 1'bz;

  i2c_mem_slave #(.freqSystem(50000000), .SYNC_STAGES(2), .DEPTH(128)) dut (
    .clk      (clk),
    .rst      (rst),
    .scl      (scl),
    .sda      (sda),
    .busy     (busy),
    .wr_done  (wr_done),
    .rd_done  (rd_done),
    .ack_err  (ack_err),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int wr_cnt = 0, wr_exp = 0;
  int rd_cnt = 0, rd_exp = 0;
  int err_pulses = 0;
  logic [7:0] model_mem [128];
  logic [7:0] exp_q [$];
  logic [7:0] rx_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One scl period; b=1 releases sda, r is sda sampled mid-high
  task automatic bus_bit(input logic b, output logic r);
    sda_low = ~b;
    wait_clk(Q);
    scl = 1'b1;
    wait_clk(Q);
    r = sda;
    wait_clk(Q);
    scl = 1'b0;
    wait_clk(Q);
  endtask

  task automatic i2c_start();
    sda_low = 1'b0;
    wait_clk(Q);
    scl = 1'b1;
    wait_clk(Q);
    sda_low = 1'b1;
    wait_clk(Q);
    scl = 1'b0;
    wait_clk(Q);
  endtask

  task automatic i2c_stop();
    sda_low = 1'b1;
    wait_clk(Q);
    scl = 1'b1;
    wait_clk(Q);
    sda_low = 1'b0;
    wait_clk(2 * Q);
  endtask

  task automatic send_byte(input logic [7:0] b, input string name);
    logic r;
    for (int i = 7; i >= 0; i--) bus_bit(b[i], r);
    bus_bit(1'b1, r);
    check(name, {31'd0, r}, 32'd0);
  endtask

  task automatic recv_byte(input logic nack, output logic [7:0] v);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      bus_bit(1'b1, r);
      v[i] = r;
    end
    bus_bit(nack, r);
  endtask

  task automatic write_txn(input logic [6:0] addr, input int n, input logic [31:0] d,
                           input bit do_stop);
    logic [6:0] a;
    logic [7:0] b;
    i2c_start();
    send_byte({addr, 1'b0}, "addr ack (write)");
    for (int i = 0; i < n; i++) begin
      b = d[8*i +: 8];
      send_byte(b, "data ack");
      a = addr + 7'(i);
      model_mem[a] = b;
      wr_exp++;
    end
    if (do_stop) begin
      i2c_stop();
      check("busy after write stop", {31'd0, busy}, 32'd0);
      check("wr_done count", wr_cnt, wr_exp);
    end
  endtask

  task automatic read_txn(input logic [6:0] addr, input int n);
    logic [6:0] a;
    logic [7:0] v;
    i2c_start();
    send_byte({addr, 1'b1}, "addr ack (read)");
    for (int i = 0; i < n; i++) begin
      a = addr + 7'(i);
      exp_q.push_back(model_mem[a]);
      recv_byte(i == n - 1, v);
      rx_q.push_back(v);
      rd_exp++;
    end
    check("busy while waiting for stop", {31'd0, busy}, 32'd1);
    check("sda released after nack", {31'd0, sda}, 32'd1);
    i2c_stop();
    check("busy after read stop", {31'd0, busy}, 32'd0);
    check("rd_done count", rd_cnt, rd_exp);
  endtask

  task automatic check_mem(input logic [6:0] a);
    dbg_addr = a;
    #1;
    check($sformatf("mem[%02h]", a), {24'd0, dbg_data}, {24'd0, model_mem[a]});
  endtask

  // Scoreboard: compares every byte the master received against the model's expectation
  initial begin
    logic [7:0] got;
    forever begin
      @(negedge clk);
      while (rx_q.size() > 0) begin
        got = rx_q.pop_front();
        if (exp_q.size() == 0) check("read data (no expectation)", {24'd0, got}, 32'hFFFF_FFFF);
        else check("read data", {24'd0, got}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  always @(negedge clk) begin
    if (wr_done === 1'b1) wr_cnt++;
    if (rd_done === 1'b1) rd_cnt++;
    if (ack_err !== 1'b0) err_pulses++;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic r;
    logic [6:0] ra;
    int n;
    rst = 1'b1;
    scl = 1'b1;
    sda_low = 1'b0;
    dbg_addr = 7'd0;
    for (int i = 0; i < 128; i++) model_mem[i] = 8'h00;
    wait_clk(4);
    rst = 1'b0;
    wait_clk(4);

    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset wr_done", {31'd0, wr_done}, 32'd0);
    check("reset rd_done", {31'd0, rd_done}, 32'd0);
    check("reset sda released", {31'd0, sda}, 32'd1);
    check_mem(7'h12);
    check_mem(7'h7F);

    write_txn(7'h12, 1, 32'h0000_00A5, 1'b1);
    check_mem(7'h12);
    read_txn(7'h12, 1);

    write_txn(7'h7E, 3, 32'h0033_2211, 1'b1);
    check_mem(7'h7E);
    check_mem(7'h7F);
    check_mem(7'h00);
    read_txn(7'h7F, 2);

    write_txn(7'h08, 2, 32'h0000_C35A, 1'b1);
    write_txn(7'h08, 0, 32'h0, 1'b0);
    read_txn(7'h08, 2);

    // Reset during the 4th data bit of a write
    write_txn(7'h30, 0, 32'h0, 1'b0);
    for (int i = 0; i < 3; i++) bus_bit(1'b1, r);
    sda_low = 1'b0;
    wait_clk(Q);
    scl = 1'b1;
    wait_clk(Q);
    rst = 1'b1;
    wait_clk(1);
    check("sda released in reset", {31'd0, sda}, 32'd1);
    check("busy cleared by reset", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 128; i++) model_mem[i] = 8'h00;
    wait_clk(4 * Q);
    check_mem(7'h30);
    check_mem(7'h12);

    for (int t = 0; t < 20; t++) begin
      ra = 7'($urandom_range(0, 127));
      n  = $urandom_range(1, 4);
      if ($urandom_range(0, 1) == 1) write_txn(ra, n, $urandom, 1'b1);
      else read_txn(ra, n);
      check_mem(ra);
      check_mem(7'($urandom_range(0, 127)));
    end

    wait_clk(4);
    check("unconsumed read expectations", exp_q.size(), 32'd0);
    check("ack_err pulses", err_pulses, 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
